// File: rtl/karaoke_line_sequencer_pkg.sv
// Shared constants and types for the karaoke line sequencer.
// Holds default glyph geometry, the FIFO depth and the sequencer state encoding.
// No ports; imported by the interface, the FIFO and the top.
package karaoke_line_sequencer_pkg;

  localparam int CHAR_H     = 8;  // column slice height in bits
  localparam int CHAR_W     = 4;  // columns per character
  localparam int CPSBLN     = 2;  // characters per subline line
  localparam int SEQ_FIFO_D = 4;  // output FIFO depth, also the read credit limit

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Index width that stays legal for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/karaoke_line_sequencer_if.sv
// ROM-bank and display-stream bundle of the karaoke line sequencer.
// master = sequencer: drives rom_en/rom_addr and the out_* stream, takes rom_data/out_ready.
// slave  = ROM bank plus display: the mirror image.
interface karaoke_line_sequencer_if #(
  parameter int N_SL   = 3,
  parameter int CHAR_H = karaoke_line_sequencer_pkg::CHAR_H,
  parameter int ADDR_W = 3,
  parameter int COL_W  = 2,
  parameter int CHR_W  = 1,
  parameter int LN_W   = 1
);

  logic                     rom_en;
  logic [ADDR_W-1:0]        rom_addr;
  logic [N_SL*CHAR_H-1:0]   rom_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_SL*CHAR_H-1:0]   out_data;
  logic [COL_W-1:0]         col_idx;
  logic [CHR_W-1:0]         char_idx;
  logic [LN_W-1:0]          line_idx;

  modport master (
    output rom_en, rom_addr, out_valid, out_data, col_idx, char_idx, line_idx,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_en, rom_addr, out_valid, out_data, col_idx, char_idx, line_idx,
    output rom_data, out_ready
  );

endinterface

// File: rtl/karaoke_line_sequencer_seq_col_fifo.sv
// seq_col_fifo: small synchronous FIFO carrying a column slice plus its index sideband.
// Ports: i_clk/i_rst (sync, active high), i_push/i_data/i_side in, i_pop in,
//        o_data/o_side show the head (valid when !o_empty), o_empty/o_full status.
module seq_col_fifo
  import karaoke_line_sequencer_pkg::*;
#(
  parameter int DW    = 24,
  parameter int SW    = 5,
  parameter int DEPTH = SEQ_FIFO_D
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic [SW-1:0] i_side,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic [SW-1:0] o_side,
  output logic          o_empty,
  output logic          o_full
);

  localparam int PW = idx_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [DW-1:0] r_data [DEPTH];
  logic [SW-1:0] r_side [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_data[r_rd_ptr];
  assign o_side  = r_side[r_rd_ptr];

  // Pointers rely on DEPTH being a power of two so they wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= i_data;
        r_side[r_wr_ptr] <= i_side;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/karaoke_line_sequencer.sv
// karaoke_line_sequencer: walks one shared column address over N_SL subline ROMs and
// streams the returned column slices, with col/char/line indices, over valid/ready.
// Ports: i_clk, i_rst (sync, active high), i_start, i_advance; bus (master) carries the
//        ROM read port and the display stream; o_line_done, o_song_done, o_busy status.
module karaoke_line_sequencer #(
  parameter int N_SL    = 3,
  parameter int CHAR_H  = karaoke_line_sequencer_pkg::CHAR_H,
  parameter int CHAR_W  = karaoke_line_sequencer_pkg::CHAR_W,
  parameter int CPSBLN  = karaoke_line_sequencer_pkg::CPSBLN,
  parameter int N_LINES = 1,
  parameter int LOOP    = 0,
  parameter int ADDR_W  = $clog2(N_LINES*CPSBLN*CHAR_W)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_advance,
  karaoke_line_sequencer_if.master bus,
  output logic                     o_line_done,
  output logic                     o_song_done,
  output logic                     o_busy
);

  import karaoke_line_sequencer_pkg::*;

  localparam int DW    = N_SL*CHAR_H;
  localparam int COL_W = idx_w(CHAR_W);
  localparam int CHR_W = idx_w(CPSBLN);
  localparam int LN_W  = $clog2(N_LINES) + 1;
  localparam int SW    = LN_W + CHR_W + COL_W;
  localparam int CR_W  = $clog2(SEQ_FIFO_D) + 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CHAR_W - 1);
  localparam logic [CHR_W-1:0] CHR_LAST = CHR_W'(CPSBLN - 1);
  localparam logic [LN_W-1:0]  LN_LAST  = LN_W'(N_LINES - 1);
  localparam logic [CR_W-1:0]  CR_MAX   = CR_W'(SEQ_FIFO_D);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [COL_W-1:0]  r_col;
  logic [CHR_W-1:0]  r_chr;
  logic [LN_W-1:0]   r_line;
  logic [CR_W-1:0]   r_credit;
  logic              r_rd_pend;
  logic [SW-1:0]     r_rd_side;
  logic              r_adv_pend;

  logic              w_issue;
  logic              w_restart;
  logic              w_pop;
  logic              w_line_end;
  logic              w_last_line;
  logic              w_drained;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [DW-1:0]     w_head_data;
  logic [SW-1:0]     w_head_side;
  logic [COL_W-1:0]  w_head_col;
  logic [CHR_W-1:0]  w_head_chr;
  logic [LN_W-1:0]   w_head_line;

  assign w_line_end  = (r_col == COL_LAST) && (r_chr == CHR_LAST);
  assign w_last_line = (r_line == LN_LAST);
  assign w_drained   = w_fifo_empty && !r_rd_pend;

  // Next state plus the issue/restart strobes it implies.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_restart   = 1'b1;
        end
      end
      ST_RUN: begin
        // Credit covers both reads in flight and FIFO entries, so the FIFO never overflows.
        w_issue = (r_credit < CR_MAX) && !w_fifo_full;
        if (w_issue && w_line_end) begin
          w_state_nxt = (w_last_line && (LOOP == 0)) ? ST_DONE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_adv_pend && w_drained) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue-side counters; they wrap to zero after the final column of the song.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr    <= '0;
      r_col     <= '0;
      r_chr     <= '0;
      r_line    <= '0;
      r_rd_pend <= 1'b0;
      r_rd_side <= '0;
    end else begin
      r_rd_pend <= w_issue;
      if (w_restart) begin
        r_addr <= '0;
        r_col  <= '0;
        r_chr  <= '0;
        r_line <= '0;
      end else if (w_issue) begin
        r_rd_side <= {r_line, r_chr, r_col};
        r_addr    <= (w_line_end && w_last_line) ? '0 : r_addr + 1'b1;
        if (r_col != COL_LAST) begin
          r_col <= r_col + 1'b1;
        end else begin
          r_col <= '0;
          if (r_chr != CHR_LAST) begin
            r_chr <= r_chr + 1'b1;
          end else begin
            r_chr  <= '0;
            r_line <= w_last_line ? '0 : r_line + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_credit   <= '0;
      r_adv_pend <= 1'b0;
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase
      // An advance only counts while holding; leaving HOLD consumes it.
      if (r_state == ST_HOLD) begin
        if (w_state_nxt == ST_RUN) begin
          r_adv_pend <= 1'b0;
        end else if (i_advance) begin
          r_adv_pend <= 1'b1;
        end
      end else begin
        r_adv_pend <= 1'b0;
      end
    end
  end

  seq_col_fifo #(
    .DW    (DW),
    .SW    (SW),
    .DEPTH (SEQ_FIFO_D)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_rd_pend),
    .i_data  (bus.rom_data),
    .i_side  (r_rd_side),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_side  (w_head_side),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign {w_head_line, w_head_chr, w_head_col} = w_head_side;
  assign w_pop = !w_fifo_empty && bus.out_ready;

  assign bus.rom_en    = w_issue;
  assign bus.rom_addr  = r_addr;
  // Head contents are masked while empty so idle outputs read as zero.
  assign bus.out_valid = !w_fifo_empty;
  assign bus.out_data  = w_fifo_empty ? '0 : w_head_data;
  assign bus.col_idx   = w_fifo_empty ? '0 : w_head_col;
  assign bus.char_idx  = w_fifo_empty ? '0 : w_head_chr;
  assign bus.line_idx  = w_fifo_empty ? '0 : w_head_line;

  assign o_line_done = w_pop && (w_head_col == COL_LAST) && (w_head_chr == CHR_LAST);
  assign o_song_done = (r_state == ST_DONE);
  assign o_busy      = (r_state == ST_RUN) || (r_state == ST_HOLD);

endmodule

// File: tb/tb_karaoke_line_sequencer.sv
// Directed bench: two sequencers (LOOP=0 and LOOP=1) share stimulus, each with its own ROM model.
// Cycle c of a scenario is the cycle whose inputs are driven just after its rising edge;
// outputs are sampled at the following falling edge.
module tb_karaoke_line_sequencer;

  logic clk;
  logic rst;
  logic start;
  logic advance;
  logic ready;
  logic ld0, sd0, bz0;
  logic ld1, sd1, bz1;
  int   n_tests;
  int   n_fail;

  karaoke_line_sequencer_if #(.N_SL(3), .CHAR_H(8), .ADDR_W(4), .COL_W(2), .CHR_W(1), .LN_W(2)) b0();
  karaoke_line_sequencer_if #(.N_SL(3), .CHAR_H(8), .ADDR_W(4), .COL_W(2), .CHR_W(1), .LN_W(2)) b1();

  karaoke_line_sequencer #(.N_SL(3), .CHAR_H(8), .CHAR_W(4), .CPSBLN(2), .N_LINES(2), .LOOP(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_advance(advance), .bus(b0),
    .o_line_done(ld0), .o_song_done(sd0), .o_busy(bz0)
  );

  karaoke_line_sequencer #(.N_SL(3), .CHAR_H(8), .CHAR_W(4), .CPSBLN(2), .N_LINES(2), .LOOP(1)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_advance(advance), .bus(b1),
    .o_line_done(ld1), .o_song_done(sd1), .o_busy(bz1)
  );

  function automatic logic [23:0] rom_word(input int a);
    return {8'(a + 2), 8'(a + 1), 8'(a)};
  endfunction

  assign b0.out_ready = ready;
  assign b1.out_ready = ready;

  always @(posedge clk) if (b0.rom_en) b0.rom_data <= rom_word(int'(b0.rom_addr));
  always @(posedge clk) if (b1.rom_en) b1.rom_data <= rom_word(int'(b1.rom_addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; advance = 1'b0; ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; advance = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({b0.rom_en, b0.rom_addr, b0.out_valid, b0.out_data, b0.col_idx, b0.char_idx, b0.line_idx, ld0, sd0, bz0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%0h vld=%b dat=%0h col=%0d chr=%0d ln=%0d ld=%b sd=%b bz=%b, want all 0",
               b0.rom_en, b0.rom_addr, b0.out_valid, b0.out_data, b0.col_idx, b0.char_idx, b0.line_idx, ld0, sd0, bz0);
    end
    n_tests++;
    if ({b1.rom_en, b1.out_valid, sd1, bz1} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_loop: got en=%b vld=%b sd=%b bz=%b, want 0", b1.rom_en, b1.out_valid, sd1, bz1);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bz0 !== 1'b0 || b0.rom_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: got busy=%b rom_en=%b, want 0 0", bz0, b0.rom_en);
    end
    @(posedge clk); #1;
  endtask

  // Full line with no backpressure: issue cycles 1..8, output cycles 3..10, then HOLD.
  task automatic test_line_stream();
    logic e_en, e_vld, e_ld;
    int a;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      start = (c == 0);
      @(negedge clk);
      e_en  = (c >= 1 && c <= 8);
      e_vld = (c >= 3 && c <= 10);
      e_ld  = (c == 10);
      a     = c - 3;
      n_tests++;
      if (b0.rom_en !== e_en) begin
        n_fail++; $display("FAIL stream_rom_en c%0d: got %b want %b", c, b0.rom_en, e_en);
      end
      if (e_en) begin
        n_tests++;
        if (b0.rom_addr !== 4'(c - 1)) begin
          n_fail++; $display("FAIL stream_rom_addr c%0d: got %0d want %0d", c, b0.rom_addr, c - 1);
        end
      end
      n_tests++;
      if (b0.out_valid !== e_vld) begin
        n_fail++; $display("FAIL stream_out_valid c%0d: got %b want %b", c, b0.out_valid, e_vld);
      end
      if (e_vld) begin
        n_tests++;
        if (b0.out_data !== rom_word(a) || b0.col_idx !== 2'(a % 4) || b0.char_idx !== 1'(a / 4) || b0.line_idx !== 2'd0) begin
          n_fail++;
          $display("FAIL stream_beat c%0d: got dat=%0h col=%0d chr=%0d ln=%0d want dat=%0h col=%0d chr=%0d ln=0",
                   c, b0.out_data, b0.col_idx, b0.char_idx, b0.line_idx, rom_word(a), a % 4, a / 4);
        end
      end
      n_tests++;
      if (ld0 !== e_ld) begin
        n_fail++; $display("FAIL stream_line_done c%0d: got %b want %b", c, ld0, e_ld);
      end
      n_tests++;
      if (bz0 !== (c >= 1) || sd0 !== 1'b0) begin
        n_fail++; $display("FAIL stream_busy c%0d: got busy=%b song_done=%b want %b 0", c, bz0, sd0, (c >= 1));
      end
      @(posedge clk); #1;
    end
  endtask

  // out_ready low for cycles 4..9: head frozen at address 1, issue stalls at four credits.
  task automatic test_backpressure();
    logic e_en, e_vld, e_ld;
    int ea, a;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      start = (c == 0);
      ready = !(c >= 4 && c <= 9);
      @(negedge clk);
      e_en  = (c >= 1 && c <= 5) || (c >= 11 && c <= 13);
      ea    = (c <= 5) ? c - 1 : c - 6;
      e_vld = (c >= 3 && c <= 16);
      a     = (c == 3) ? 0 : ((c <= 10) ? 1 : c - 9);
      e_ld  = (c == 16);
      n_tests++;
      if (b0.rom_en !== e_en) begin
        n_fail++; $display("FAIL bp_rom_en c%0d: got %b want %b", c, b0.rom_en, e_en);
      end
      if (e_en) begin
        n_tests++;
        if (b0.rom_addr !== 4'(ea)) begin
          n_fail++; $display("FAIL bp_rom_addr c%0d: got %0d want %0d", c, b0.rom_addr, ea);
        end
      end
      n_tests++;
      if (b0.out_valid !== e_vld) begin
        n_fail++; $display("FAIL bp_out_valid c%0d: got %b want %b", c, b0.out_valid, e_vld);
      end
      if (e_vld) begin
        n_tests++;
        if (b0.out_data !== rom_word(a) || b0.col_idx !== 2'(a % 4) || b0.char_idx !== 1'(a / 4)) begin
          n_fail++;
          $display("FAIL bp_beat c%0d: got dat=%0h col=%0d chr=%0d want dat=%0h col=%0d chr=%0d",
                   c, b0.out_data, b0.col_idx, b0.char_idx, rom_word(a), a % 4, a / 4);
        end
      end
      n_tests++;
      if (ld0 !== e_ld) begin
        n_fail++; $display("FAIL bp_line_done c%0d: got %b want %b", c, ld0, e_ld);
      end
      @(posedge clk); #1;
    end
    ready = 1'b1;
  endtask

  // advance during RUN (cycle 5) must not release the next line.
  task automatic test_early_advance();
    logic e_en;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      start   = (c == 0);
      advance = (c == 5);
      @(negedge clk);
      e_en = (c >= 1 && c <= 8);
      n_tests++;
      if (b0.rom_en !== e_en) begin
        n_fail++; $display("FAIL early_adv_rom_en c%0d: got %b want %b", c, b0.rom_en, e_en);
      end
      if (c >= 9) begin
        n_tests++;
        if (bz0 !== 1'b1 || sd0 !== 1'b0) begin
          n_fail++; $display("FAIL early_adv_hold c%0d: got busy=%b song_done=%b want 1 0", c, bz0, sd0);
        end
      end
      @(posedge clk); #1;
    end
    advance = 1'b0;
  endtask

  // advance at cycle 9 (HOLD, line 0 still draining) releases line 1 at cycle 12.
  task automatic test_advance_in_hold();
    logic e_en, e_vld, e_ld;
    int ea, a;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      start   = (c == 0);
      advance = (c == 9);
      @(negedge clk);
      e_en  = (c >= 1 && c <= 8) || (c >= 12 && c <= 19);
      ea    = (c <= 8) ? c - 1 : c - 4;
      e_vld = (c >= 3 && c <= 10) || (c >= 14 && c <= 21);
      a     = (c <= 10) ? c - 3 : c - 6;
      e_ld  = (c == 10) || (c == 21);
      n_tests++;
      if (b0.rom_en !== e_en) begin
        n_fail++; $display("FAIL hold_rom_en c%0d: got %b want %b", c, b0.rom_en, e_en);
      end
      if (e_en) begin
        n_tests++;
        if (b0.rom_addr !== 4'(ea)) begin
          n_fail++; $display("FAIL hold_rom_addr c%0d: got %0d want %0d", c, b0.rom_addr, ea);
        end
      end
      n_tests++;
      if (b0.out_valid !== e_vld) begin
        n_fail++; $display("FAIL hold_out_valid c%0d: got %b want %b", c, b0.out_valid, e_vld);
      end
      if (e_vld) begin
        n_tests++;
        if (b0.out_data !== rom_word(a) || b0.col_idx !== 2'(a % 4) || b0.char_idx !== 1'((a / 4) % 2) ||
            b0.line_idx !== 2'(a / 8)) begin
          n_fail++;
          $display("FAIL hold_beat c%0d: got dat=%0h col=%0d chr=%0d ln=%0d want dat=%0h col=%0d chr=%0d ln=%0d",
                   c, b0.out_data, b0.col_idx, b0.char_idx, b0.line_idx, rom_word(a), a % 4, (a / 4) % 2, a / 8);
        end
      end
      n_tests++;
      if (ld0 !== e_ld) begin
        n_fail++; $display("FAIL hold_line_done c%0d: got %b want %b", c, ld0, e_ld);
      end
      n_tests++;
      if (sd0 !== (c >= 20) || bz0 !== (c >= 1 && c <= 19)) begin
        n_fail++;
        $display("FAIL hold_song_done c%0d: got song_done=%b busy=%b want %b %b", c, sd0, bz0, (c >= 20), (c >= 1 && c <= 19));
      end
      @(posedge clk); #1;
    end
    advance = 1'b0;
  endtask

  // LOOP=1 wraps to address 0 / line 0 after a second advance; LOOP=0 sits in DONE.
  task automatic test_loop();
    do_reset();
    for (int c = 0; c < 28; c++) begin
      start   = (c == 0);
      advance = (c == 9) || (c == 22);
      @(negedge clk);
      n_tests++;
      if (sd1 !== 1'b0) begin
        n_fail++; $display("FAIL loop_song_done c%0d: got %b want 0", c, sd1);
      end
      if (c == 21) begin
        n_tests++;
        if (ld1 !== 1'b1 || b1.line_idx !== 2'd1) begin
          n_fail++; $display("FAIL loop_last_beat c%0d: got line_done=%b ln=%0d want 1 1", c, ld1, b1.line_idx);
        end
      end
      if (c == 23) begin
        n_tests++;
        if (b1.rom_en !== 1'b0 || bz1 !== 1'b1) begin
          n_fail++; $display("FAIL loop_hold c%0d: got rom_en=%b busy=%b want 0 1", c, b1.rom_en, bz1);
        end
      end
      if (c == 24 || c == 25) begin
        n_tests++;
        if (b1.rom_en !== 1'b1 || b1.rom_addr !== 4'(c - 24)) begin
          n_fail++; $display("FAIL loop_wrap_addr c%0d: got en=%b addr=%0d want 1 %0d", c, b1.rom_en, b1.rom_addr, c - 24);
        end
        n_tests++;
        if (b0.rom_en !== 1'b0 || sd0 !== 1'b1 || bz0 !== 1'b0) begin
          n_fail++; $display("FAIL loop_noloop_done c%0d: got en=%b sd=%b bz=%b want 0 1 0", c, b0.rom_en, sd0, bz0);
        end
      end
      if (c == 26 || c == 27) begin
        n_tests++;
        if (b1.out_valid !== 1'b1 || b1.out_data !== rom_word(c - 26) || b1.line_idx !== 2'd0 ||
            b1.char_idx !== 1'b0 || b1.col_idx !== 2'(c - 26)) begin
          n_fail++;
          $display("FAIL loop_wrap_beat c%0d: got vld=%b dat=%0h ln=%0d chr=%0d col=%0d want 1 %0h 0 0 %0d",
                   c, b1.out_valid, b1.out_data, b1.line_idx, b1.char_idx, b1.col_idx, rom_word(c - 26), c - 26);
        end
      end
      @(posedge clk); #1;
    end
    advance = 1'b0;
  endtask

  // Reset pulse at cycle 6 mid-line; stale ROM return at cycle 7 must be dropped.
  task automatic test_mid_reset();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      start = (c == 0) || (c == 9);
      rst   = (c == 6);
      @(negedge clk);
      if (c == 7) begin
        n_tests++;
        if ({b0.rom_en, b0.rom_addr, b0.out_valid, b0.out_data, b0.col_idx, b0.char_idx, b0.line_idx, ld0, sd0, bz0} !== '0) begin
          n_fail++;
          $display("FAIL midrst_outputs c%0d: got en=%b addr=%0d vld=%b dat=%0h col=%0d bz=%b, want all 0",
                   c, b0.rom_en, b0.rom_addr, b0.out_valid, b0.out_data, b0.col_idx, bz0);
        end
      end
      if (c == 8 || c == 9) begin
        n_tests++;
        if (b0.out_valid !== 1'b0) begin
          n_fail++; $display("FAIL midrst_stale c%0d: got out_valid=%b want 0", c, b0.out_valid);
        end
      end
      if (c == 10) begin
        n_tests++;
        if (b0.rom_en !== 1'b1 || b0.rom_addr !== 4'd0) begin
          n_fail++; $display("FAIL midrst_restart_addr c%0d: got en=%b addr=%0d want 1 0", c, b0.rom_en, b0.rom_addr);
        end
      end
      if (c == 12) begin
        n_tests++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== rom_word(0) || b0.col_idx !== 2'd0) begin
          n_fail++;
          $display("FAIL midrst_first_beat c%0d: got vld=%b dat=%0h col=%0d want 1 %0h 0", c, b0.out_valid, b0.out_data, b0.col_idx, rom_word(0));
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_line_stream();
    test_backpressure();
    test_early_advance();
    test_advance_in_hold();
    test_loop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/karaoke_line_sequencer.md
Name: karaoke_line_sequencer

Overview:
Parametrised successor to the fixed 3-subline lyric bench. It drives N_SL subline column ROMs from one shared address counter and streams CHAR_H-bit column slices to the display over valid/ready. Lines are paced by an advance handshake instead of a hard simulation stop. It sits between the buslistROM bank and the display/bench, and supports optional looping of the song.

Parameters:
N_SL, 3, number of sublines (ROM channels)
CHAR_H, `CHAR_H, column slice height in bits
CHAR_W, `CHAR_W, columns per character
CPSBLN, `CPSBLN, characters per subline line
N_LINES, 1, lines per song
LOOP, 0, 1 = wrap to line 0 after last line; 0 = stop in DONE
ADDR_W, $clog2(N_LINES*CPSBLN*CHAR_W), ROM address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse; begin song from address 0 (honoured in IDLE/DONE only)
advance  in  1  pulse; release next line (honoured in HOLD only)
rom_en  out  1  read strobe to all subline ROMs
rom_addr  out  ADDR_W  shared column address
rom_data  in  N_SL*CHAR_H  concatenated ROM read data, subline 0 in LSBs; valid cycle after rom_en
out_valid  out  1  column slice valid
out_ready  in  1  downstream accepts
out_data  out  N_SL*CHAR_H  column slices
col_idx  out  $clog2(CHAR_W)  column within char
char_idx  out  $clog2(CPSBLN)  char within line
line_idx  out  $clog2(N_LINES)+1  line number
line_done  out  1  one-cycle pulse when last column of a line is accepted
song_done  out  1  level, high in DONE
busy  out  1  high in RUN or HOLD

Behaviour:
- Reset: every output 0; state IDLE; counters, FIFO, credit and pending flags cleared. Any ROM return arriving the cycle after reset is discarded (rd_pending cleared by reset).
- States:
  - IDLE --start--> RUN.
  - RUN --last column of a non-final line issued--> HOLD.
  - RUN --last column of final line issued--> DONE (LOOP=0) or HOLD (LOOP=1).
  - HOLD --(adv_pend && drained)--> RUN.
  - DONE --start--> RUN.
- advance sampled in HOLD sets adv_pend. It is ignored in other states.
- drained = FIFO empty and no read in flight.
- Leaving HOLD clears adv_pend. The next line continues at the next address; with LOOP=1 after the final line, address, char and line counters wrap to 0.
- Issue rule: rom_en=1 in RUN when credit<4. credit = issued-not-yet-popped; +1 on issue, -1 on output handshake, both in the same cycle is net 0.
- Pipeline: cycle 0 start sampled; cycle 1 rom_addr=0, rom_en=1; cycle 2 rom_data valid, pushed to the 4-entry FIFO with sideband indices; cycle 3 out_valid=1.
- Throughput: 1 column/cycle sustained while out_ready=1.
- out_data and indices are held stable while out_valid && !out_ready. There is no loss or duplication under any backpressure pattern.
- Counter nesting: col_idx 0..CHAR_W-1, then char_idx 0..CPSBLN-1, then line_idx; these travel with the data.
- line_done is asserted on the handshake of col_idx=CHAR_W-1, char_idx=CPSBLN-1.
- song_done and DONE are entered on issue of the final column. Output-side draining continues normally in DONE. A start received in DONE before drain is completed still restarts at address 0, but FIFO contents drain first, in order.
- start and advance in the same cycle: only the one valid for the current state acts.

Decomposition:
- Shared package/definitions.vh: CHAR_H, CHAR_W, CPSBLN, state encodings (ST_IDLE, ST_RUN, ST_HOLD, ST_DONE), FIFO depth constant SEQ_FIFO_D=4.
- One sub-module: seq_col_fifo, a 4-deep synchronous FIFO with data plus sideband, push/pop/empty/full, same clk/rst.

Test Plan:
Config for all scenarios: N_SL=3, CHAR_W=4, CPSBLN=2, N_LINES=2, so 8 columns per line. The ROM model returns {addr+2,addr+1,addr}.
- Reset: rst high 2 cycles → all outputs 0; start ignored during reset; busy=0.
- Line stream: start at cycle 0 with out_ready=1 → rom_addr 0..7 on cycles 1..8; out_valid cycles 3..10; col_idx 0,1,2,3,0,1,2,3; char_idx 0×4 then 1×4; line_done pulses at cycle 10 only; then HOLD with rom_en=0.
- Backpressure: out_ready=0 cycles 4..9 → out_data frozen at addr 1; rom_en drops once credit=4; on release, addresses 1..7 are delivered in order with none missing.
- Early advance: advance at cycle 5 during RUN → ignored, stays in HOLD. advance in HOLD before drain → latched; rom_addr=8 issued the cycle after drain. Line 1 ends → song_done=1, line_idx=1 on the last beat.
- LOOP=1: after line 1 plus advance → rom_addr=0, line_idx=0, song_done stays 0.
- Reset mid-line at cycle 6 → cycle 7 all outputs 0; stale rom_data ignored; start then restarts at rom_addr=0 with col_idx 0.
